// File: rtl/mult_err_profiler.sv
// Exhaustive accuracy profiler for an external combinational NxN multiplier: sweeps all (a,b) pairs
// and accumulates error count, error-distance sum and worst case. Define BIAS_EN to build the signed bias accumulator.
module mult_err_profiler #(
   parameter int N     = 8,
   parameter int ACC_W = 40
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic [N-1:0]            a,
   output logic [N-1:0]            b,
   input  logic [2*N-1:0]          Y,
   output logic                    busy,
   output logic                    done,
   output logic [2*N:0]            err_count,
   output logic [ACC_W-1:0]        ed_sum,
   output logic [2*N-1:0]          max_ed,
   output logic [N-1:0]            max_a,
   output logic [N-1:0]            max_b,
   output logic signed [ACC_W:0]   bias_sum
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     a_q, a_d, b_q, b_d;
   logic [2*N:0]     err_count_q, err_count_d;
   logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
   logic [2*N-1:0]   max_ed_q, max_ed_d;
   logic [N-1:0]     max_a_q, max_a_d, max_b_q, max_b_d;
   logic [2*N-1:0]   p, ed;
   logic             launch, last_pair;

`ifdef BIAS_EN
   logic signed [ACC_W:0] bias_sum_q, bias_sum_d;
   logic signed [2*N:0]   diff;
`endif

   always_comb begin
      p         = (2*N)'(a_q) * (2*N)'(b_q);
      ed        = (Y >= p) ? (Y - p) : (p - Y);
      launch    = start && (state_q != RUN);
      last_pair = (a_q == '1) && (b_q == '1);

      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      err_count_d = err_count_q;
      ed_sum_d    = ed_sum_q;
      max_ed_d    = max_ed_q;
      max_a_d     = max_a_q;
      max_b_d     = max_b_q;
`ifdef BIAS_EN
      diff       = $signed({1'b0, Y}) - $signed({1'b0, p});
      bias_sum_d = bias_sum_q;
`endif

      if (launch) begin
         state_d     = RUN;
         a_d         = '0;
         b_d         = '0;
         err_count_d = '0;
         ed_sum_d    = '0;
         max_ed_d    = '0;
         max_a_d     = '0;
         max_b_d     = '0;
`ifdef BIAS_EN
         bias_sum_d  = '0;
`endif
      end else if (state_q == RUN) begin
         err_count_d = err_count_q + (2*N+1)'(ed != '0);
         ed_sum_d    = ed_sum_q + ACC_W'(ed);
`ifdef BIAS_EN
         bias_sum_d  = bias_sum_q + (ACC_W+1)'(diff);
`endif
         // strict compare so ties keep the earliest pair in sweep order
         if (ed > max_ed_q) begin
            max_ed_d = ed;
            max_a_d  = a_q;
            max_b_d  = b_q;
         end
         if (last_pair) begin
            state_d = DONE;
         end else begin
            b_d = b_q + 1'b1;
            if (b_q == '1) a_d = a_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         err_count_q <= '0;
         ed_sum_q    <= '0;
         max_ed_q    <= '0;
         max_a_q     <= '0;
         max_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         err_count_q <= err_count_d;
         ed_sum_q    <= ed_sum_d;
         max_ed_q    <= max_ed_d;
         max_a_q     <= max_a_d;
         max_b_q     <= max_b_d;
      end
   end

`ifdef BIAS_EN
   always_ff @(posedge clk) begin
      if (rst) bias_sum_q <= '0;
      else     bias_sum_q <= bias_sum_d;
   end
   assign bias_sum = bias_sum_q;
`else
   assign bias_sum = '0;
`endif

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign err_count = err_count_q;
   assign ed_sum    = ed_sum_q;
   assign max_ed    = max_ed_q;
   assign max_a     = max_a_q;
   assign max_b     = max_b_q;

endmodule
